// File: rtl/upower_pkg.sv
// Shared widths, the fetch FSM state encoding and the default end-of-program
// marker for the uPower datapath.
package upower_pkg;

  localparam int INSN_W = 32;
  localparam int PC_W   = 32;

  // An all-zero word marks the end of the program.
  localparam logic [INSN_W-1:0] HALT_INSN_DEFAULT = '0;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/upower_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC for the
// decoder.
//
// Handshake: the word in instr/pc is transferred on every clock edge where
// valid && ready. valid never drops without a transfer, except on flush.
// While valid && !ready, instr, pc and valid all hold. A load may replace a
// word in the same cycle it is transferred. flush wins over load and drops
// the held word whether or not it is being transferred that cycle.
module upower_if_id_reg
  import upower_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              ready,
  input  logic [INSN_W-1:0] instr_d,
  input  logic [PC_W-1:0]   pc_d,
  output logic              valid,
  output logic [INSN_W-1:0] instr,
  output logic [PC_W-1:0]   pc
);

  // Flush beats load. A load refills the register. Otherwise a transfer empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/upower_fetch_unit.sv
// Fetch stage: owns the PC and drives the word address to the combinational
// instruction memory. It feeds the IF/ID register and handles branch
// redirects, decoder back-pressure and end-of-program halt.
module upower_fetch_unit
  import upower_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter int unsigned       IMEM_DEPTH = 3,
  parameter logic [INSN_W-1:0] HALT_INSN  = HALT_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic              if_valid,
  output logic [INSN_W-1:0] if_instr,
  output logic [PC_W-1:0]   if_pc,
  input  logic              id_ready,
  output logic              halted,
  output logic [31:0]       fetch_count,
  output logic [1:0]        fetch_state
);

  localparam logic [1:0] IDLE   = FS_IDLE;
  localparam logic [1:0] FETCH  = FS_FETCH;
  localparam logic [1:0] HALTED = FS_HALTED;

  logic [1:0]      state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic            redirect_take;
  logic            fire;
  logic            past_end;
  logic            is_halt;
  logic            load;

  // A redirect outside IDLE overrides everything else, including a stalled word.
  assign redirect_take = redirect_valid && (state != IDLE);
  // The register has room when it is empty or its word leaves this cycle.
  assign fire          = (state == FETCH) && (!if_valid || id_ready) && !redirect_valid;
  assign past_end      = pc >= PC_W'(IMEM_DEPTH);
  assign is_halt       = imem_data == HALT_INSN;
  // Words past the end of memory and the halt marker are never forwarded.
  assign load          = fire && !past_end && !is_halt;

  assign imem_addr   = pc;
  assign halted      = state == HALTED;
  assign fetch_state = state;

  // Next-state and next-PC selection. Redirect first, then per-state behaviour.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_take) begin
      state_next = FETCH;
      pc_next    = redirect_target;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_next = FETCH;
        end
        FETCH: begin
          if (fire) begin
            if (load) pc_next = pc + PC_W'(1);
            else      state_next = HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Count every word handed to the decoder, in any state. The count wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count <= '0;
    else if (if_valid && id_ready) fetch_count <= fetch_count + 32'd1;
  end

  upower_if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_take),
    .load    (load),
    .ready   (id_ready),
    .instr_d (imem_data),
    .pc_d    (pc),
    .valid   (if_valid),
    .instr   (if_instr),
    .pc      (if_pc)
  );

endmodule

// File: doc/upower_fetch_unit.md
Name: upower_fetch_unit

Overview:
Fetch stage of the uPower datapath, directly upstream of the instruction-memory read block. Owns the program counter and drives the word address into the combinational instruction memory. Latches the returned 32-bit instruction into an IF/ID output register with a valid/ready handshake to the decoder. Handles branch redirects, decoder back-pressure, and end-of-program halt.

Parameters:
RESET_PC, 0, word index loaded into the PC on reset
IMEM_DEPTH, 3, number of instruction words present; a PC at or beyond this halts fetch
HALT_INSN, 32'h0000_0000, instruction encoding treated as end-of-program marker

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE and begins fetching
imem_addr  out  32  word index to instruction memory; equals current PC, combinational from the PC register
imem_data  in  32  instruction word returned combinationally for imem_addr
redirect_valid  in  1  decoder/branch unit requests a PC change
redirect_target  in  32  new PC word index
if_valid  out  1  IF/ID register holds an instruction
if_instr  out  32  latched instruction
if_pc  out  32  PC the latched instruction came from
id_ready  in  1  decoder accepts if_instr this cycle
halted  out  1  fetch has stopped
fetch_count  out  32  number of instructions handed to the decoder (if_valid && id_ready)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - PC held; if_valid stays 0.
  - start -> FETCH next cycle.
- FETCH: a fetch "fires" when (!if_valid || id_ready) && !redirect_valid. On fire:
  - pc >= IMEM_DEPTH: no latch, if_valid<=0 unless the held word is consumed-and-replaced, -> HALTED.
  - imem_data == HALT_INSN: not forwarded; if_valid<=0 if consumed, pc held, -> HALTED.
  - Otherwise: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1.
- Stall: if_valid && !id_ready && !redirect_valid. pc, if_instr, if_pc, and if_valid all hold.
- Latency: address presented in cycle n -> if_instr/if_valid visible from cycle n+1. Throughput is 1 instr/cycle with id_ready held high.
- Redirect (any state except IDLE) has highest priority:
  - pc<=redirect_target and if_valid<=0 (flush, even if id_ready is low).
  - No fetch fires that cycle.
  - State -> FETCH, halted<=0; this also leaves HALTED, because the halt was speculative.
  - Redirect while in IDLE is ignored.
- HALTED:
  - halted=1; pc frozen.
  - A pending if_valid word is still delivered and clears on id_ready.
  - start is ignored.
- fetch_count increments on every cycle with if_valid && id_ready, including during HALTED drain and on a redirect cycle where the word is accepted. Wraps modulo 2^32.
- PC arithmetic is 32-bit unsigned and wraps at 2^32 (bounded by the IMEM_DEPTH halt in practice).
- start in FETCH or HALTED is ignored.
- rst asserted mid-operation returns everything to reset values immediately; any in-flight instruction is dropped.

Decomposition:
- Shared package upower_pkg holds:
  - fetch_state_t enum (IDLE, FETCH, HALTED)
  - INSN_W=32, PC_W=32
  - HALT_INSN default constant
- One natural sub-module: upower_if_id_reg, the valid/ready output register holding if_instr, if_pc, and if_valid, with flush and load controls.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset then start, memory {A,B,C} (IMEM_DEPTH=3), id_ready=1 -> imem_addr 0,1,2 on consecutive cycles; if_instr A,B,C with if_pc 0,1,2 one cycle later; halted=1 after pc reaches 3; fetch_count=3.
- id_ready low for 3 cycles after the first word -> if_instr=A and imem_addr=1 held for the whole stall; B appears the cycle after id_ready rises; no word lost or duplicated.
- redirect_valid with target 0 while if_valid=1 and id_ready=0 -> if_valid=0 next cycle, imem_addr=0, then A re-fetched; fetch_count unchanged by the flushed word.
- Memory {A,HALT_INSN,C} -> A delivered, halted=1, C never fetched; a later redirect to 2 clears halted and delivers C with if_pc=2.
- rst pulsed asynchronously mid-fetch (not clock-aligned) -> outputs go to reset values immediately; state IDLE; no fetch until a new start.
- start pulsed during FETCH and in HALTED -> no effect on pc, state, or fetch_count.
